// File: rtl/vga_palette_mux.sv
// Two-stage pixel formatter: turns tagged frame-BRAM words into RGB (grey, pen palette with blink,
// inverted-grey cursor highlight) and delays hsync/vsync/blank by the same two cycles.
module vga_palette_mux #(
    parameter int PIXEL_W     = 8,
    parameter int COLOR_W     = 12,
    parameter int NUM_PENS    = 4,
    parameter int BLINK_SHIFT = 4
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic [PIXEL_W-1:0]           pixel_in,
    input  logic                         hsync_in,
    input  logic                         vsync_in,
    input  logic                         blank_in,
    input  logic                         pal_we_in,
    input  logic [$clog2(NUM_PENS)-1:0]  pal_addr_in,
    input  logic [COLOR_W:0]             pal_data_in,
    output logic [COLOR_W-1:0]           pixel_out,
    output logic                         hsync_out,
    output logic                         vsync_out,
    output logic                         blank_out
);
    localparam int PAY_W = PIXEL_W - 2;
    localparam int CH_W  = COLOR_W / 3;
    localparam int PEN_W = $clog2(NUM_PENS);
    localparam int REP   = (CH_W + 3) / 4;

    // Stretch or truncate a 4-bit reference channel to CH_W by repeating it MSB-first.
    function automatic logic [CH_W-1:0] scale_ch(input logic [3:0] c);
        logic [4*REP-1:0] rep;
        rep = {REP{c}};
        return rep[4*REP-1 -: CH_W];
    endfunction

    function automatic logic [COLOR_W:0] reset_entry(input int idx);
        logic [11:0] rgb12;
        case (idx)
            0:       rgb12 = 12'h00F;
            1:       rgb12 = 12'hFF0;
            2:       rgb12 = 12'hA26;
            default: rgb12 = 12'hFFF;
        endcase
        return {1'b0, scale_ch(rgb12[11:8]), scale_ch(rgb12[7:4]), scale_ch(rgb12[3:0])};
    endfunction

    logic [COLOR_W:0]   pal_reg [NUM_PENS];
    logic [PAY_W-1:0]   payload_s1;
    logic [1:0]         tag_s1;
    logic               hsync_s1;
    logic               vsync_s1;
    logic               blank_s1;
    logic               vsync_prev;
    logic [7:0]         frame_cnt;
    logic [CH_W-1:0]    grey_lvl;
    logic [PEN_W-1:0]   pen;
    logic [COLOR_W:0]   pen_entry;
    logic               blink_phase;
    logic [COLOR_W-1:0] color_next;

    // Palette lives in flops so that reset can restore every entry at once.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NUM_PENS; i++) begin
                pal_reg[i] <= reset_entry(i);
            end
        end else if (pal_we_in) begin
            pal_reg[pal_addr_in] <= pal_data_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            payload_s1 <= '0;
            tag_s1     <= '0;
            hsync_s1   <= 1'b0;
            vsync_s1   <= 1'b0;
            blank_s1   <= 1'b0;
            vsync_prev <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            payload_s1 <= pixel_in[PAY_W-1:0];
            tag_s1     <= pixel_in[PIXEL_W-1:PIXEL_W-2];
            hsync_s1   <= hsync_in;
            vsync_s1   <= vsync_in;
            blank_s1   <= blank_in;
            vsync_prev <= vsync_in;
            if (vsync_in && !vsync_prev) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    assign grey_lvl    = payload_s1[PAY_W-1 -: CH_W];
    assign pen         = payload_s1[PEN_W-1:0];
    assign pen_entry   = pal_reg[pen];
    assign blink_phase = frame_cnt[BLINK_SHIFT];

    // A blinking pen in its "off" phase falls back to the grey reading of the same payload.
    always_comb begin
        color_next = {3{grey_lvl}};
        case (tag_s1)
            2'b11: begin
                if (!(pen_entry[COLOR_W] && blink_phase)) begin
                    color_next = pen_entry[COLOR_W-1:0];
                end
            end
            2'b10:   color_next = {3{~grey_lvl}};
            default: color_next = {3{grey_lvl}};
        endcase
        if (blank_s1) begin
            color_next = '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pixel_out <= '0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
            blank_out <= 1'b0;
        end else begin
            pixel_out <= color_next;
            hsync_out <= hsync_s1;
            vsync_out <= vsync_s1;
            blank_out <= blank_s1;
        end
    end
endmodule

// File: tb/tb_vga_palette_mux.sv
// Self-checking bench for vga_palette_mux: fixed vector table, hand sequences for palette
// collision / blink / reset, and a randomized stream checked against a transaction-level model.
module tb_vga_palette_mux;
    localparam int PIXEL_W     = 8;
    localparam int COLOR_W     = 12;
    localparam int NUM_PENS    = 4;
    localparam int BLINK_SHIFT = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  pixel;
    logic        hs, vs, bl, we;
    logic [1:0]  addr;
    logic [12:0] data;
    logic [11:0] pix_o;
    logic        hs_o, vs_o, bl_o;

    always #5 clk = ~clk;

    vga_palette_mux #(
        .PIXEL_W(PIXEL_W), .COLOR_W(COLOR_W), .NUM_PENS(NUM_PENS), .BLINK_SHIFT(BLINK_SHIFT)
    ) dut (
        .clk_in(clk), .rst_n_in(rst_n), .pixel_in(pixel), .hsync_in(hs), .vsync_in(vs),
        .blank_in(bl), .pal_we_in(we), .pal_addr_in(addr), .pal_data_in(data),
        .pixel_out(pix_o), .hsync_out(hs_o), .vsync_out(vs_o), .blank_out(bl_o)
    );

    typedef struct {
        logic [7:0]  pix;
        logic        hs, vs, bl, we;
        logic [1:0]  addr;
        logic [12:0] data;
    } in_t;
    typedef struct packed {
        logic [11:0] pix;
        logic        hs, vs, bl;
    } out_t;
    typedef struct {
        logic [7:0]  pix;
        logic        bl;
        logic [11:0] exp_pix;
        logic        exp_bl;
    } vec_t;

    int checks = 0;
    int passes = 0;

    // Reference model: palette contents, frame count, and the input accepted on the last edge.
    logic [12:0] pal_m [NUM_PENS];
    int          frame_m;
    logic        vs_prev_m;
    in_t         held;
    bit          held_valid;

    function automatic in_t mk(input logic [7:0] p, input logic b);
        in_t v;
        v.pix = p; v.hs = 1'b0; v.vs = 1'b0; v.bl = b; v.we = 1'b0; v.addr = 2'd0; v.data = 13'd0;
        return v;
    endfunction

    function automatic out_t render(input in_t v);
        out_t        r;
        logic [3:0]  g;
        logic [12:0] e;
        g = v.pix[5:2];
        e = pal_m[v.pix[1:0]];
        r.hs = v.hs; r.vs = v.vs; r.bl = v.bl;
        r.pix = {g, g, g};
        if (v.pix[7:6] == 2'b11) begin
            if (!(e[12] && (((frame_m >> BLINK_SHIFT) & 1) == 1))) r.pix = e[11:0];
        end else if (v.pix[7:6] == 2'b10) begin
            r.pix = {~g, ~g, ~g};
        end
        if (v.bl) r.pix = 12'h000;
        return r;
    endfunction

    task automatic model_reset();
        pal_m[0] = 13'h000F; pal_m[1] = 13'h0FF0; pal_m[2] = 13'h0A26; pal_m[3] = 13'h0FFF;
        frame_m = 0; vs_prev_m = 1'b0; held_valid = 1'b0;
    endtask

    task automatic check_bits(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h, required %h", name, got, exp);
    endtask

    task automatic check_out(input string name, input out_t exp);
        out_t got;
        got = {pix_o, hs_o, vs_o, bl_o};
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got pix=%h hs=%b vs=%b bl=%b, required pix=%h hs=%b vs=%b bl=%b",
                      name, got.pix, got.hs, got.vs, got.bl, exp.pix, exp.hs, exp.vs, exp.bl);
    endtask

    // Apply one input word for one clock, advance the model, and compare against it.
    task automatic cycle(input in_t v, input string name);
        out_t exp;
        pixel = v.pix; hs = v.hs; vs = v.vs; bl = v.bl; we = v.we; addr = v.addr; data = v.data;
        @(posedge clk);
        exp = held_valid ? render(held) : out_t'(0);
        if (v.we) pal_m[v.addr] = v.data;
        if (v.vs && !vs_prev_m) frame_m = (frame_m + 1) % 256;
        vs_prev_m = v.vs;
        held = v;
        held_valid = 1'b1;
        #1;
        $display("%-10s in=%h hs=%b vs=%b bl=%b we=%b | out=%h hs=%b vs=%b bl=%b | model=%h",
                 name, v.pix, v.hs, v.vs, v.bl, v.we, pix_o, hs_o, vs_o, bl_o, exp.pix);
        check_out(name, exp);
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        #1;
        check_bits(name, {pix_o, hs_o, vs_o, bl_o}, 16'h0000);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    vec_t vt [8];
    in_t  v;

    initial begin
        vt[0] = '{8'h3C, 1'b0, 12'hFFF, 1'b0};
        vt[1] = '{8'h08, 1'b0, 12'h222, 1'b0};
        vt[2] = '{8'hC0, 1'b0, 12'h00F, 1'b0};
        vt[3] = '{8'hC1, 1'b0, 12'hFF0, 1'b0};
        vt[4] = '{8'hC2, 1'b0, 12'hA26, 1'b0};
        vt[5] = '{8'hC3, 1'b0, 12'hFFF, 1'b0};
        vt[6] = '{8'h80, 1'b0, 12'hFFF, 1'b0};
        vt[7] = '{8'h80, 1'b1, 12'h000, 1'b1};

        pixel = 8'h00; hs = 1'b0; vs = 1'b0; bl = 1'b0; we = 1'b0; addr = 2'd0; data = 13'd0;
        rst_n = 1'b1;
        #2;
        do_reset("reset_init");

        // Table vectors: vector i shows up after the edge that samples vector i+1.
        for (int i = 0; i <= 8; i++) begin
            cycle(i < 8 ? mk(vt[i].pix, vt[i].bl) : mk(8'h00, 1'b0), "table");
            if (i >= 1) begin
                check_bits("table_pix", {4'h0, pix_o}, {4'h0, vt[i-1].exp_pix});
                check_bits("table_blank", {15'h0, bl_o}, {15'h0, vt[i-1].exp_bl});
            end
        end

        // Write lands on the same edge the first C1 is looked up.
        cycle(mk(8'hC1, 1'b0), "coll_a");
        v = mk(8'hC1, 1'b0); v.we = 1'b1; v.addr = 2'd1; v.data = 13'h00F0;
        cycle(v, "coll_b");
        check_bits("collision_old", {4'h0, pix_o}, 16'h0FF0);
        cycle(mk(8'h00, 1'b0), "coll_c");
        check_bits("collision_new", {4'h0, pix_o}, 16'h00F0);

        // Blink on pen 2 with the blink phase on frame bit 1.
        do_reset("reset_blink");
        v = mk(8'hE2, 1'b0); v.we = 1'b1; v.addr = 2'd2; v.data = 13'h1A26;
        cycle(v, "blink_wr");
        repeat (3) cycle(mk(8'hE2, 1'b0), "blink");
        check_bits("blink_off0", {4'h0, pix_o}, 16'h0A26);
        for (int p = 0; p < 2; p++) begin
            v = mk(8'hE2, 1'b0); v.vs = 1'b1;
            cycle(v, "blink_vs");
            cycle(mk(8'hE2, 1'b0), "blink");
        end
        repeat (2) cycle(mk(8'hE2, 1'b0), "blink");
        check_bits("blink_grey", {4'h0, pix_o}, 16'h0888);
        for (int p = 0; p < 2; p++) begin
            v = mk(8'hE2, 1'b0); v.vs = 1'b1;
            cycle(v, "blink_vs");
            cycle(mk(8'hE2, 1'b0), "blink");
        end
        repeat (2) cycle(mk(8'hE2, 1'b0), "blink");
        check_bits("blink_back", {4'h0, pix_o}, 16'h0A26);

        // Reset mid-stream must clear outputs at once and restore the default palette.
        v = mk(8'hC1, 1'b0); v.we = 1'b1; v.addr = 2'd1; v.data = 13'h00F0;
        v.hs = 1'b1; v.vs = 1'b1;
        cycle(v, "pre_rst");
        repeat (2) cycle(mk(8'hC1, 1'b0), "pre_rst");
        check_bits("pen1_written", {4'h0, pix_o}, 16'h00F0);
        do_reset("reset_mid");
        repeat (3) cycle(mk(8'hC1, 1'b0), "post_rst");
        check_bits("pen1_restored", {4'h0, pix_o}, 16'h0FF0);

        // Randomized stream: every cycle compared against the model.
        for (int n = 0; n < 300; n++) begin
            v.pix  = 8'($urandom);
            v.hs   = 1'($urandom_range(0, 1));
            v.vs   = 1'($urandom_range(0, 1));
            v.bl   = ($urandom_range(0, 7) == 0);
            v.we   = ($urandom_range(0, 7) == 0);
            v.addr = 2'($urandom);
            v.data = 13'($urandom);
            cycle(v, "random");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
